// File: rtl/regfile_onehot_wr_if.sv
// Bus bundle for the one-hot-write register file. The master drives the write/read
// controls, and the slave returns the read data and the decode-fault status.
interface regfile_onehot_wr_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
);
  logic                     ctrl_writeEnable;
  logic [31:0]              ctrl_writeSelect;
  logic [DATA_WIDTH-1:0]    data_writeReg;
  logic [4:0]               ctrl_readRegA;
  logic [4:0]               ctrl_readRegB;
  logic [DATA_WIDTH-1:0]    data_readRegA;
  logic [DATA_WIDTH-1:0]    data_readRegB;
  logic                     ctrl_clearError;
  logic                     err_select;
  logic [ERR_CNT_WIDTH-1:0] err_count;

  modport master (
    output ctrl_writeEnable, ctrl_writeSelect, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB, ctrl_clearError,
    input  data_readRegA, data_readRegB, err_select, err_count
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeSelect, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB, ctrl_clearError,
    output data_readRegA, data_readRegB, err_select, err_count
  );
endinterface

// File: rtl/regfile_onehot_wr.sv
// 32-entry register file with a one-hot write select, write-first bypass, and a sticky
// monitor for malformed selects. r0 always reads as zero.
module regfile_onehot_wr #(
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  regfile_onehot_wr_if.slave bus
);

  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0]    regs_q [32];
  logic [DATA_WIDTH-1:0]    regs_d [32];
  logic                     err_select_q, err_select_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic       sel_valid;
  logic [4:0] wr_idx;
  logic       wr_ok;
  logic       wr_bad;

  always_comb begin
    sel_valid = $onehot(bus.ctrl_writeSelect);
    wr_idx    = '0;
    for (int i = 0; i < 32; i++) begin
      if (bus.ctrl_writeSelect[i]) wr_idx = i[4:0];
    end
    // A select of r0 is legal, but it has no effect on any register.
    wr_ok  = bus.ctrl_writeEnable && sel_valid && (wr_idx != 5'd0);
    wr_bad = bus.ctrl_writeEnable && !sel_valid;
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wr_idx] = bus.data_writeReg;
  end

  // A malformed write on the same edge as a clear takes priority, so the count restarts at 1.
  always_comb begin
    err_select_d = err_select_q;
    err_count_d  = err_count_q;
    if (bus.ctrl_clearError) begin
      err_select_d = 1'b0;
      err_count_d  = '0;
    end
    if (wr_bad) begin
      err_select_d = 1'b1;
      if (bus.ctrl_clearError)       err_count_d = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
      else if (err_count_q != CNT_MAX) err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      err_select_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      regs_q       <= regs_d;
      err_select_q <= err_select_d;
      err_count_q  <= err_count_d;
    end
  end

  always_comb begin
    bus.data_readRegA = regs_q[bus.ctrl_readRegA];
    if (wr_ok && (wr_idx == bus.ctrl_readRegA)) bus.data_readRegA = bus.data_writeReg;
    if (bus.ctrl_readRegA == 5'd0) bus.data_readRegA = '0;

    bus.data_readRegB = regs_q[bus.ctrl_readRegB];
    if (wr_ok && (wr_idx == bus.ctrl_readRegB)) bus.data_readRegB = bus.data_writeReg;
    if (bus.ctrl_readRegB == 5'd0) bus.data_readRegB = '0;

    bus.err_select = err_select_q;
    bus.err_count  = err_count_q;
  end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Testbench for regfile_onehot_wr. The stimulus process queues the expected value of each
// output for the current cycle, and the monitor checks the queue on every falling edge.
module tb_regfile_onehot_wr;

  localparam int DW = 32;
  localparam int CW = 8;

  logic clock;
  logic ctrl_reset;

  regfile_onehot_wr_if #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) bus ();

  regfile_onehot_wr #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum int {K_RDA, K_RDB, K_ERR, K_CNT} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always @(negedge clock) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_RDA:   act = bus.data_readRegA;
        K_RDB:   act = bus.data_readRegB;
        K_ERR:   act = {31'd0, bus.err_select};
        default: act = {{(32-CW){1'b0}}, bus.err_count};
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_v(input string name, input kind_e kind, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic step(input logic we, input logic [31:0] sel, input logic [31:0] data,
                      input logic [4:0] ra, input logic [4:0] rb, input logic clr);
    @(posedge clock);
    #1;
    bus.ctrl_writeEnable = we;
    bus.ctrl_writeSelect = sel;
    bus.data_writeReg    = data;
    bus.ctrl_readRegA    = ra;
    bus.ctrl_readRegB    = rb;
    bus.ctrl_clearError  = clr;
  endtask

  initial begin
    ctrl_reset           = 1'b0;
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeSelect = '0;
    bus.data_writeReg    = '0;
    bus.ctrl_readRegA    = '0;
    bus.ctrl_readRegB    = '0;
    bus.ctrl_clearError  = 1'b0;
    repeat (2) @(posedge clock);
    #1 ctrl_reset = 1'b1;

    step(0, 32'h0, 32'h0, 5'd5, 5'd7, 0);
    expect_v("rst_rda", K_RDA, 32'h0);
    expect_v("rst_err", K_ERR, 32'h0);
    expect_v("rst_cnt", K_CNT, 32'h0);

    // Load r5, record one malformed write, then assert reset in the middle of a cycle.
    step(1, 32'h0000_0020, 32'hDEAD_BEEF, 5'd0, 5'd0, 0);
    step(1, 32'h0000_0003, 32'h1111_1111, 5'd0, 5'd0, 0);
    step(0, 32'h0, 32'h0, 5'd5, 5'd0, 0);
    expect_v("pre_rst_r5", K_RDA, 32'hDEAD_BEEF);
    expect_v("pre_rst_err", K_ERR, 32'h1);
    expect_v("pre_rst_cnt", K_CNT, 32'h1);
    step(1, 32'h0000_0040, 32'h6666_6666, 5'd5, 5'd6, 0);
    ctrl_reset = 1'b0;
    expect_v("in_rst_r5", K_RDA, 32'h0);
    expect_v("in_rst_err", K_ERR, 32'h0);
    expect_v("in_rst_cnt", K_CNT, 32'h0);
    step(0, 32'h0, 32'h0, 5'd5, 5'd6, 0);
    ctrl_reset = 1'b1;
    step(0, 32'h0, 32'h0, 5'd5, 5'd6, 0);
    expect_v("post_rst_r5", K_RDA, 32'h0);
    expect_v("rst_held_wr_ignored_r6", K_RDB, 32'h0);

    step(1, 32'h0000_0100, 32'h1234_5678, 5'd8, 5'd9, 0);
    expect_v("bypass_r8", K_RDA, 32'h1234_5678);
    expect_v("r9_zero", K_RDB, 32'h0);
    step(0, 32'h0, 32'h0, 5'd8, 5'd9, 0);
    expect_v("array_r8", K_RDA, 32'h1234_5678);
    expect_v("r9_zero_next", K_RDB, 32'h0);

    step(1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0, 0);
    expect_v("r0_bypass_blocked", K_RDA, 32'h0);
    step(0, 32'h0, 32'h0, 5'd0, 5'd8, 0);
    expect_v("r0_stays_zero", K_RDA, 32'h0);
    expect_v("r0_sel_no_err", K_ERR, 32'h0);
    expect_v("r8_untouched", K_RDB, 32'h1234_5678);

    step(1, 32'h0000_0002, 32'h0000_0011, 5'd0, 5'd0, 0);
    step(1, 32'h0000_0004, 32'h0000_0022, 5'd0, 5'd0, 0);
    step(1, 32'h0000_0006, 32'h0000_0BAD, 5'd1, 5'd2, 0);
    expect_v("mal_no_bypass_a", K_RDA, 32'h11);
    expect_v("mal_no_bypass_b", K_RDB, 32'h22);
    step(1, 32'h0000_0000, 32'h0000_0BAD, 5'd1, 5'd2, 0);
    expect_v("mal1_err", K_ERR, 32'h1);
    expect_v("mal1_cnt", K_CNT, 32'h1);
    step(0, 32'h0000_0006, 32'h0000_0BAD, 5'd1, 5'd2, 0);
    expect_v("mal2_cnt", K_CNT, 32'h2);
    expect_v("mal_r1_kept", K_RDA, 32'h11);
    expect_v("mal_r2_kept", K_RDB, 32'h22);
    step(0, 32'h0000_0000, 32'h0, 5'd1, 5'd2, 0);
    step(0, 32'h0, 32'h0, 5'd1, 5'd2, 0);
    expect_v("we0_cnt_held", K_CNT, 32'h2);
    expect_v("we0_err_held", K_ERR, 32'h1);

    for (int i = 0; i < 300; i++) begin
      step(1, 32'h0000_0003, 32'h0, 5'd1, 5'd2, 0);
      if (i == 100) expect_v("sat_mid_cnt", K_CNT, 32'd102);
      if (i == 253) expect_v("sat_edge_cnt", K_CNT, 32'd255);
    end
    step(0, 32'h0, 32'h0, 5'd1, 5'd2, 0);
    expect_v("sat_cnt", K_CNT, 32'd255);
    expect_v("sat_r1_kept", K_RDA, 32'h11);

    step(1, 32'h0000_000C, 32'h0, 5'd0, 5'd0, 1);
    step(0, 32'h0, 32'h0, 5'd0, 5'd0, 0);
    expect_v("clr_vs_mal_err", K_ERR, 32'h1);
    expect_v("clr_vs_mal_cnt", K_CNT, 32'h1);
    step(0, 32'h0, 32'h0, 5'd0, 5'd0, 1);
    step(0, 32'h0, 32'h0, 5'd0, 5'd0, 0);
    expect_v("clr_err", K_ERR, 32'h0);
    expect_v("clr_cnt", K_CNT, 32'h0);

    step(1, 32'h8000_0000, 32'hA5A5_A5A5, 5'd31, 5'd31, 0);
    expect_v("dual_a", K_RDA, 32'hA5A5_A5A5);
    expect_v("dual_b", K_RDB, 32'hA5A5_A5A5);
    step(1, 32'h8000_0000, 32'h5A5A_5A5A, 5'd31, 5'd31, 0);
    expect_v("dual_over_a", K_RDA, 32'h5A5A_5A5A);
    expect_v("dual_over_b", K_RDB, 32'h5A5A_5A5A);
    step(1, 32'h8000_0001, 32'h0F0F_0F0F, 5'd31, 5'd0, 0);
    expect_v("mal_hi_no_bypass", K_RDA, 32'h5A5A_5A5A);
    expect_v("r0_port_b", K_RDB, 32'h0);
    step(0, 32'h0, 32'h0, 5'd31, 5'd8, 0);
    expect_v("no_partial_r31", K_RDA, 32'h5A5A_5A5A);
    expect_v("r8_still", K_RDB, 32'h1234_5678);
    expect_v("mal_hi_err", K_ERR, 32'h1);
    step(1, 32'h0000_0100, 32'h0000_CAFE, 5'd8, 5'd31, 0);
    expect_v("single_port_bypass", K_RDA, 32'h0000_CAFE);
    expect_v("other_port_array", K_RDB, 32'h5A5A_5A5A);
    step(0, 32'h0, 32'h0, 5'd8, 5'd0, 0);

    repeat (3) @(negedge clock);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_onehot_wr.md
Name: regfile_onehot_wr

Overview:
- 32 x DATA_WIDTH processor register file sitting directly downstream of the 5-bit one-hot decoder.
- The write port takes the decoder's 32-bit one-hot write select directly; the read ports take raw 5-bit register numbers.
- Adds write-first bypass and a sticky malformed-select error monitor so decode faults are caught at the register file, not propagated.
- r0 is hardwired to zero.

Parameters:
DATA_WIDTH, 32, width of each register and data port
ERR_CNT_WIDTH, 8, width of the saturating malformed-select counter

Ports:
clock  in  1  single clock; all state updates on rising edge
ctrl_reset  in  1  asynchronous, active-low reset; 0 = reset asserted
ctrl_writeEnable  in  1  write request this cycle
ctrl_writeSelect  in  32  one-hot destination select from the decoder; bit i selects ri
data_writeReg  in  DATA_WIDTH  write data
ctrl_readRegA  in  5  read port A register number
ctrl_readRegB  in  5  read port B register number
data_readRegA  out  DATA_WIDTH  read port A data (combinational)
data_readRegB  out  DATA_WIDTH  read port B data (combinational)
ctrl_clearError  in  1  synchronous clear of error flag and counter
err_select  out  1  sticky: malformed select seen with write enable high
err_count  out  ERR_CNT_WIDTH  number of malformed-select writes, saturating

Behaviour:
- Reset (ctrl_reset=0, asynchronous, any time including mid-write):
  - all registers, err_select and err_count go to 0 immediately;
  - writes on edges while reset is held are ignored.
- Select classification, combinational on ctrl_writeSelect:
  - valid: exactly one bit set;
  - malformed: zero bits set, or two or more bits set.
- Write, on rising clock edge when ctrl_writeEnable=1:
  - valid select with bit i set, i != 0: ri <= data_writeReg; written value is visible through the array from the next cycle.
  - valid select with bit 0 set: no state change, not an error; r0 stays 0.
  - malformed select: no register changes (no partial write to any selected bit).
    - err_select <= 1;
    - err_count <= err_count+1, holding at 2^ERR_CNT_WIDTH-1 (no wrap).
- ctrl_writeEnable=0: ctrl_writeSelect is ignored entirely; no write, no error.
- Read ports:
  - purely combinational;
  - readReg = 0 -> output 0 regardless of bypass;
  - otherwise the output is the array value, except as below.
- Write-first bypass:
  - if ctrl_writeEnable=1, select is valid, its set bit index equals the read number, and the read number != 0, the port outputs data_writeReg in the same cycle.
  - Both ports bypass independently; A and B with the same number both bypass.
  - No bypass on a malformed select.
- ctrl_clearError=1 at an edge:
  - err_select <= 0 and err_count <= 0;
  - if a malformed write occurs on the same edge, the error wins: err_select <= 1, err_count <= 1.
- Latency:
  - write-to-array 1 edge;
  - read 0 cycles (combinational);
  - error flag asserted 1 edge after the offending write.

Test Plan:
- Reset: drive ctrl_reset=0 mid-cycle after writing r5=0xDEADBEEF -> all reads return 0 immediately; err_select=0, err_count=0.
- Basic write/read: WE=1, select=0x0000_0100, data=0x1234_5678; readA=8 same cycle -> 0x12345678 via bypass. Next cycle with WE=0 -> readA=8 still 0x12345678; readB=9 -> 0.
- r0 protection: WE=1, select=0x0000_0001, data=0xFFFF_FFFF -> readA=0 gives 0 in that cycle and the next; err_select stays 0.
- Malformed selects: select=0x0000_0006 with WE=1, then 0x0000_0000 with WE=1 -> r1 and r2 unchanged, no bypass on readA=1; err_select=1, err_count=2. The same selects with WE=0 leave the count at 2.
- Saturation and clear (ERR_CNT_WIDTH=8): 300 consecutive malformed writes -> err_count=255. Then ctrl_clearError=1 together with a malformed write -> err_select=1, err_count=1. Then clear alone -> both 0.
- Dual-port bypass: WE=1, select=1<<31, data=0xA5A5_A5A5, readA=readB=31 -> both 0xA5A5A5A5 same cycle. The next cycle's write to r31 overrides it and both ports follow.
